// File: rtl/clock_mode_controller.sv
// ---------------------------------------------------------------------------
// clock_mode_controller
//
// Purpose:
//   Owns the hour/min/sec time registers that feed time_displayer. In RUN
//   mode the time advances on a 1 Hz enable. Three set modes let the user
//   adjust one field at a time with inc/dec buttons, and the field being
//   edited blinks through a per-field blank mask.
//
// Ports:
//   clk_src      in   system clock, all logic on the rising edge
//   rst          in   synchronous, active-high reset
//   tick_1hz     in   one-cycle enable, once per second
//   btn_mode     in   one-cycle debounced pulse, advances the mode
//   btn_inc      in   one-cycle pulse, increments the selected field
//   btn_dec      in   one-cycle pulse, decrements the selected field
//   sec_data     out  [WIDTH-1:0] seconds 0..59, upper bits zero
//   min_data     out  [WIDTH-1:0] minutes 0..59, upper bits zero
//   hour_data    out  [WIDTH-1:0] hours 0..23, upper bits zero
//   mode         out  [1:0] 0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
//   blank        out  [2:0] {hour,min,sec} blank request, 1 = blank digits
//   hour_strobe  out  one-cycle pulse on an hour rollover while running
// ---------------------------------------------------------------------------
module clock_mode_controller #(
    parameter int WIDTH     = 32,
    parameter int BLINK_DIV = 25000000
) (
    input  logic             clk_src,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             btn_dec,
    output logic [WIDTH-1:0] sec_data,
    output logic [WIDTH-1:0] min_data,
    output logic [WIDTH-1:0] hour_data,
    output logic [1:0]       mode,
    output logic [2:0]       blank,
    output logic             hour_strobe
);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2,
        MODE_SET_S = 2'd3
    } mode_t;

    localparam int              CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [5:0]      SEC_LAST  = 6'd59;
    localparam logic [5:0]      MIN_LAST  = 6'd59;
    localparam logic [5:0]      HOUR_LAST = 6'd23;

    // Registered state
    mode_t            mode_q;
    logic [5:0]       sec_q, min_q, hour_q;
    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;
    logic [2:0]       blank_q;
    logic             strobe_q;

    // Next-state values
    mode_t            mode_d;
    logic [5:0]       sec_d, min_d, hour_d;
    logic [CNT_W-1:0] cnt_d;
    logic             phase_d;
    logic [2:0]       blank_d;
    logic             strobe_d;

    // Field wrap helpers: the ">=" / "==0" forms keep the value inside its
    // legal range even if the register ever held something out of range.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
        return (v >= last) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] last);
        return (v == 6'd0 || v > last) ? last : v - 6'd1;
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_RUN:   return MODE_SET_H;
            MODE_SET_H: return MODE_SET_M;
            MODE_SET_M: return MODE_SET_S;
            default:    return MODE_RUN;
        endcase
    endfunction

    // Exactly one of inc/dec edits the field; both together cancel out.
    logic do_inc, do_dec, any_btn;
    assign do_inc  = btn_inc & ~btn_dec;
    assign do_dec  = btn_dec & ~btn_inc;
    assign any_btn = btn_inc | btn_dec;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        mode_d   = mode_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        strobe_d = 1'b0;
        blank_d  = 3'b000;

        if (btn_mode) begin
            // Mode change wins over inc/dec and restarts the blink period.
            mode_d  = next_mode(mode_q);
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (mode_q == MODE_RUN) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            if (tick_1hz) begin
                if (sec_q >= SEC_LAST) begin
                    sec_d = 6'd0;
                    if (min_q >= MIN_LAST) begin
                        min_d    = 6'd0;
                        hour_d   = wrap_inc(hour_q, HOUR_LAST);
                        strobe_d = 1'b1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end
        end else begin
            // Set modes: time is frozen, ticks are dropped.
            if (any_btn) begin
                // Restart the blink so the edited field shows immediately.
                cnt_d   = '0;
                phase_d = 1'b0;
            end else if (cnt_q >= CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            case (mode_q)
                MODE_SET_H: begin
                    if (do_inc) hour_d = wrap_inc(hour_q, HOUR_LAST);
                    if (do_dec) hour_d = wrap_dec(hour_q, HOUR_LAST);
                end
                MODE_SET_M: begin
                    if (do_inc) min_d = wrap_inc(min_q, MIN_LAST);
                    if (do_dec) min_d = wrap_dec(min_q, MIN_LAST);
                end
                default: begin
                    if (do_inc) sec_d = wrap_inc(sec_q, SEC_LAST);
                    if (do_dec) sec_d = wrap_dec(sec_q, SEC_LAST);
                end
            endcase
        end

        // Blank mask follows the next mode and phase so it lines up with
        // the registered state on the same edge.
        case (mode_d)
            MODE_SET_H: blank_d = {phase_d, 2'b00};
            MODE_SET_M: blank_d = {1'b0, phase_d, 1'b0};
            MODE_SET_S: blank_d = {2'b00, phase_d};
            default:    blank_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk_src) begin
        if (rst) begin
            // Reset discards any edit in progress and returns to RUN.
            mode_q   <= MODE_RUN;
            sec_q    <= 6'd0;
            min_q    <= 6'd0;
            hour_q   <= 6'd0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            blank_q  <= 3'b000;
            strobe_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, independent of order.
            mode_q   <= mode_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hour_q   <= hour_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            blank_q  <= blank_d;
            strobe_q <= strobe_d;
        end
    end

    assign sec_data    = {{(WIDTH-6){1'b0}}, sec_q};
    assign min_data    = {{(WIDTH-6){1'b0}}, min_q};
    assign hour_data   = {{(WIDTH-6){1'b0}}, hour_q};
    assign mode        = mode_q;
    assign blank       = blank_q;
    assign hour_strobe = strobe_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// ---------------------------------------------------------------------------
// tb_clock_mode_controller
//
// Directed bench for clock_mode_controller with BLINK_DIV = 4. Inputs are
// driven on the falling edge, held across one rising edge, and outputs are
// sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_clock_mode_controller;

    localparam int WIDTH = 32;

    logic             clk_src = 1'b0;
    logic             rst = 1'b0;
    logic             tick_1hz = 1'b0;
    logic             btn_mode = 1'b0;
    logic             btn_inc = 1'b0;
    logic             btn_dec = 1'b0;
    logic [WIDTH-1:0] sec_data, min_data, hour_data;
    logic [1:0]       mode;
    logic [2:0]       blank;
    logic             hour_strobe;

    int n_checks = 0;
    int n_errors = 0;

    clock_mode_controller #(
        .WIDTH     (WIDTH),
        .BLINK_DIV (4)
    ) dut (
        .clk_src     (clk_src),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .btn_dec     (btn_dec),
        .sec_data    (sec_data),
        .min_data    (min_data),
        .hour_data   (hour_data),
        .mode        (mode),
        .blank       (blank),
        .hour_strobe (hour_strobe)
    );

    always #5 clk_src = ~clk_src;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One clock cycle with the given inputs held across the rising edge.
    task automatic step(input logic t, input logic m, input logic i, input logic d);
        tick_1hz = t;
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        @(posedge clk_src);
        @(negedge clk_src);
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hour"}, hour_data, 32'(h));
        check({tag, ".min"},  min_data,  32'(m));
        check({tag, ".sec"},  sec_data,  32'(s));
    endtask

    initial begin
        @(negedge clk_src);

        // 1. Reset, then 61 ticks in RUN
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_time("reset", 0, 0, 0);
        check("reset.mode",   32'(mode),        32'd0);
        check("reset.blank",  32'(blank),       32'd0);
        check("reset.strobe", 32'(hour_strobe), 32'd0);

        for (int k = 0; k < 61; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_time("t61", 0, 1, 1);
        check("t61.mode",  32'(mode),  32'd0);
        check("t61.blank", 32'(blank), 32'd0);

        // 2. Preload 23:59:58 via set modes, then roll over the day
        step(1'b0, 1'b1, 1'b0, 1'b0);           // SET_H
        step(1'b0, 1'b0, 1'b0, 1'b1);           // hour 0 -> 23
        step(1'b0, 1'b1, 1'b0, 1'b0);           // SET_M
        step(1'b0, 1'b0, 1'b0, 1'b1);           // min 1 -> 0
        step(1'b0, 1'b0, 1'b0, 1'b1);           // min 0 -> 59
        step(1'b0, 1'b1, 1'b0, 1'b0);           // SET_S
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1);  // sec 1 -> 58
        check("preload.mode", 32'(mode), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0);           // RUN
        check("preload.run", 32'(mode), 32'd0);
        check_time("preload", 23, 59, 58);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_time("tick59", 23, 59, 59);
        check("tick59.strobe", 32'(hour_strobe), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_time("rollover", 0, 0, 0);
        check("rollover.strobe", 32'(hour_strobe), 32'd1);
        idle(1);
        check("after.strobe", 32'(hour_strobe), 32'd0);

        // 3. SET_H edits with wrap, ticks frozen
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("seth.mode", 32'(mode),      32'd1);
        check("seth.dec",  hour_data,      32'd23);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("seth.inc2", hour_data,      32'd1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("seth.frozen_sec", sec_data, 32'd0);
        check("seth.blank_off",  32'(blank), 32'd0);
        idle(1);
        check("seth.blank_on",   32'(blank), 32'b100);

        // 4. SET_M blink timing and restart on edit
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("setm.mode",  32'(mode),  32'd2);
        check("setm.blank0", 32'(blank), 32'b000);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            check($sformatf("setm.blink%0d", k), 32'(blank), (k >= 4) ? 32'b010 : 32'b000);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);          // mid-period edit
        check("setm.inc_blank", 32'(blank), 32'b000);
        check("setm.inc_min",   min_data,   32'd1);
        idle(3);
        check("setm.restart3",  32'(blank), 32'b000);
        idle(1);
        check("setm.restart4",  32'(blank), 32'b010);

        // 5. Simultaneous buttons
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("setm.incdec_min", min_data, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);           // SET_S
        step(1'b0, 1'b0, 1'b1, 1'b0);           // sec 0 -> 1
        idle(4);
        check("sets.blank_on", 32'(blank), 32'b001);
        step(1'b0, 1'b1, 1'b1, 1'b0);           // mode wins over inc
        check("sets.mode_prio", 32'(mode), 32'd0);
        check("sets.blank_run", 32'(blank), 32'd0);
        check_time("sets.exit", 1, 1, 1);

        // 6. Reset in the middle of an edit
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);           // SET_M
        for (int k = 0; k < 41; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("edit.min42", min_data, 32'd42);
        idle(4);
        check("edit.blank", 32'(blank), 32'b010);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_time("midreset", 0, 0, 0);
        check("midreset.mode",   32'(mode),        32'd0);
        check("midreset.blank",  32'(blank),       32'd0);
        check("midreset.strobe", 32'(hour_strobe), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_time("postreset.tick", 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
